// File: rtl/src_unpack.sv
// src_unpack: pulls 64-bit words from a source FIFO and serialises them into
// bytes for the encoder core, honouring a total byte count and an end-marker.
// Optional build macro SRC_UNPACK_SWAP_EN: present bytes MSB-first
// (SR[63:56] first) instead of the default LSB-first order.
module src_unpack #(
  parameter int LZF_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 src_empty,
  input  logic [63:0]          fi,
  input  logic                 m_last,
  input  logic [LZF_WIDTH-1:0] fi_cnt,
  output logic                 m_src_getn,
  output logic [7:0]           byte_out,
  output logic                 byte_valid,
  input  logic                 byte_ready,
  output logic                 byte_last,
  output logic                 src_donen,
  output logic                 cnt_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [63:0]          sr_q, sr_d;       // shift register being serialised
  logic [3:0]           sr_n_q, sr_n_d;   // bytes left in SR (0 = empty)
  logic [64:0]          pb_q, pb_d;       // prefetch buffer {m_last, fi}
  logic                 pb_vld_q, pb_vld_d;
  logic                 rd_q, rd_d;       // pop issued last cycle, data due now
  logic [LZF_WIDTH-1:0] cnt_q, cnt_d;     // payload bytes still to deliver
  logic                 err_q, err_d;

  logic                 pop, acc, sr_free, cnt_one;
  logic [LZF_WIDTH-1:0] acc_w;

  // Handshake decode and output drive
  always_comb begin
    // rst gating keeps the pop strobe quiet while reset is asserted
    pop        = rst && ce && !src_empty && !pb_vld_q && !rd_q &&
                 (state_q == S_RUN || state_q == S_DRAIN);
    m_src_getn = !pop;
    byte_valid = (state_q == S_RUN) && (sr_n_q != 4'd0);
    acc        = ce && byte_valid && byte_ready;
    cnt_one    = (cnt_q == LZF_WIDTH'(1));
    byte_last  = byte_valid && cnt_one;
    // SR can take a new word if empty or its final byte leaves this cycle
    sr_free    = (sr_n_q == 4'd0) || (sr_n_q == 4'd1 && acc);
    acc_w      = LZF_WIDTH'(acc);
`ifdef SRC_UNPACK_SWAP_EN
    byte_out   = sr_q[63:56];
`else
    byte_out   = sr_q[7:0];
`endif
    src_donen  = (state_q != S_DONE);
    cnt_err    = err_q;
  end

  // Next-state: FSM, buffer movement and byte counter
  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    sr_n_d   = sr_n_q;
    pb_d     = pb_q;
    pb_vld_d = pb_vld_q;
    rd_d     = pop;
    cnt_d    = cnt_q;
    err_d    = err_q;

    // An in-flight read always lands, even with ce low; PB is empty by
    // construction whenever a read is outstanding.
    if (rd_q) begin
      pb_d     = {m_last, fi};
      pb_vld_d = 1'b1;
    end

    if (ce) begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d   = fi_cnt;
          state_d = (fi_cnt == '0) ? S_DRAIN : S_RUN;
        end
        S_RUN: begin
          if (acc) begin
`ifdef SRC_UNPACK_SWAP_EN
            sr_d  = {sr_q[55:0], 8'h00};
`else
            sr_d  = {8'h00, sr_q[63:8]};
`endif
            sr_n_d = sr_n_q - 4'd1;
            cnt_d  = cnt_q - LZF_WIDTH'(1);
            if (cnt_one) begin
              // final byte taken: leftover bytes of a partial word are dropped
              state_d = S_DRAIN;
              sr_n_d  = 4'd0;
            end
          end
          if (pb_vld_q && sr_free) begin
            if (pb_q[64]) begin
              pb_vld_d = 1'b0;
              sr_n_d   = 4'd0;
              state_d  = S_DONE;
              if (cnt_q != acc_w) err_d = 1'b1;
            end else if (!(acc && cnt_one)) begin
              sr_d     = pb_q[63:0];
              sr_n_d   = 4'd8;
              pb_vld_d = 1'b0;
            end
          end
        end
        S_DRAIN: begin
          if (pb_vld_q) begin
            pb_vld_d = 1'b0;
            if (pb_q[64]) state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      sr_q     <= '0;
      sr_n_q   <= '0;
      pb_q     <= '0;
      pb_vld_q <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      sr_n_q   <= sr_n_d;
      pb_q     <= pb_d;
      pb_vld_q <= pb_vld_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

endmodule
